// File: rtl/fetch_pkg.sv
// Shared constants, halfword type and ring-index helper for the fetch buffer.
package fetch_pkg;

    localparam int unsigned WORD    = 32;
    localparam int unsigned HALF    = 16;
    localparam int unsigned WIDTH   = 4;
    localparam int unsigned BITS    = WORD * WIDTH;
    localparam int unsigned DWIDTH  = 2 * WIDTH;
    localparam int unsigned DEPTH   = 4 * DWIDTH;

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
    localparam int unsigned OFF_W   = $clog2(DWIDTH);
    localparam int unsigned AVAIL_W = $clog2(DWIDTH + 1);

    typedef logic [0:HALF-1] halfword_t;

    // Ring index advance; DEPTH is a power of two so the carry-out is the wrap.
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] idx,
                                                  input logic [PTR_W-1:0] inc);
        return idx + inc;
    endfunction

endpackage

// File: rtl/hw_rotate.sv
// Halfword rotator: picks OUT_N consecutive halfwords from a ring starting at
// base, wrapping at the end of the ring, and zeroes slots at or beyond keep.
module hw_rotate
    import fetch_pkg::*;
#(
    parameter int unsigned IN_N  = DEPTH,
    parameter int unsigned OUT_N = DWIDTH
) (
    input  halfword_t                     src [IN_N],
    input  logic [$clog2(IN_N)-1:0]       base,
    input  logic [$clog2(OUT_N+1)-1:0]    keep,
    output logic [0:OUT_N*HALF-1]         dst
);

    localparam int unsigned IDX_W  = $clog2(IN_N);
    localparam int unsigned KEEP_W = $clog2(OUT_N + 1);

    // Rotate-read with zero masking of the slots past the valid count.
    always_comb begin
        dst = '0;
        for (int k = 0; k < int'(OUT_N); k++) begin
            if (KEEP_W'(k) < keep) begin
                dst[k*HALF +: HALF] = src[IDX_W'(base + IDX_W'(k))];
            end
        end
    end

endmodule

// File: rtl/fetch_buffer.sv
// Halfword realignment queue between the I-cache fetch port and decode.
// Build option: FETCH_BUFFER_PARTIAL_EN lets decode see packets shorter than
// DWIDTH halfwords (valid on any non-empty buffer, bounded by o_avail).
module fetch_buffer
    import fetch_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_flush,
    input  logic                 i_fetch_valid,
    output logic                 o_fetch_ready,
    input  logic [0:BITS-1]      i_fetch_data,
    input  logic [OFF_W-1:0]     i_fetch_offset,
    output logic [0:BITS-1]      o_packet,
    output logic                 o_packet_valid,
    output logic [AVAIL_W-1:0]   o_avail,
    input  logic [AVAIL_W-1:0]   i_consume,
    output logic [CNT_W-1:0]     o_count
);

    halfword_t          mem [DEPTH];
    logic [PTR_W-1:0]   head;
    logic [CNT_W-1:0]   count;
    logic [PTR_W-1:0]   tail;
    logic               push;
    logic               pop;
    logic [CNT_W-1:0]   pushed;
    logic [CNT_W-1:0]   popped;

    // Status derived from registered occupancy only; no path from i_consume.
    always_comb begin
        tail          = wrap_add(head, count[PTR_W-1:0]);
        o_count       = count;
        o_fetch_ready = (count <= CNT_W'(DEPTH - DWIDTH));
        o_avail       = (count >= CNT_W'(DWIDTH)) ? AVAIL_W'(DWIDTH) : AVAIL_W'(count);
`ifdef FETCH_BUFFER_PARTIAL_EN
        o_packet_valid = (count != '0);
`else
        o_packet_valid = (count >= CNT_W'(DWIDTH));
`endif
    end

    // Push/pop qualification; a flush overrides both.
    always_comb begin
        push   = i_fetch_valid && o_fetch_ready && !i_flush;
        pop    = o_packet_valid && !i_flush;
        pushed = push ? (CNT_W'(DWIDTH) - CNT_W'(i_fetch_offset)) : '0;
        popped = pop ? CNT_W'(i_consume) : '0;
    end

    // Head and occupancy registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            head  <= '0;
            count <= '0;
        end else if (i_flush) begin
            head  <= '0;
            count <= '0;
        end else begin
            head  <= wrap_add(head, PTR_W'(popped));
            count <= count - popped + pushed;
        end
    end

    // Ring write: useful halfwords of the line land contiguously from tail.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            for (int k = 0; k < int'(DWIDTH); k++) begin
                if (OFF_W'(k) >= i_fetch_offset) begin
                    mem[wrap_add(tail, PTR_W'(k) - PTR_W'(i_fetch_offset))]
                        <= i_fetch_data[k*HALF +: HALF];
                end
            end
        end
    end

    // Packet is an unregistered rotate-read from head, masked by o_avail.
    hw_rotate #(
        .IN_N  (DEPTH),
        .OUT_N (DWIDTH)
    ) u_read_rot (
        .src  (mem),
        .base (head),
        .keep (o_avail),
        .dst  (o_packet)
    );

    // Decode may never retire more halfwords than are presented.
    a_consume_legal: assert property (@(posedge i_clk) disable iff (i_rst)
        (o_packet_valid && !i_flush) |-> (i_consume <= o_avail));

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer; expectations follow FETCH_BUFFER_PARTIAL_EN.
module tb_fetch_buffer;
    import fetch_pkg::*;

    logic                 i_clk;
    logic                 i_rst;
    logic                 i_flush;
    logic                 i_fetch_valid;
    logic                 o_fetch_ready;
    logic [0:BITS-1]      i_fetch_data;
    logic [OFF_W-1:0]     i_fetch_offset;
    logic [0:BITS-1]      o_packet;
    logic                 o_packet_valid;
    logic [AVAIL_W-1:0]   o_avail;
    logic [AVAIL_W-1:0]   i_consume;
    logic [CNT_W-1:0]     o_count;

    int n_checks = 0;
    int n_pass   = 0;

    fetch_buffer dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_flush        (i_flush),
        .i_fetch_valid  (i_fetch_valid),
        .o_fetch_ready  (o_fetch_ready),
        .i_fetch_data   (i_fetch_data),
        .i_fetch_offset (i_fetch_offset),
        .o_packet       (o_packet),
        .o_packet_valid (o_packet_valid),
        .o_avail        (o_avail),
        .i_consume      (i_consume),
        .o_count        (o_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [0:BITS-1] make_line(input logic [15:0] base);
        logic [0:BITS-1] l;
        for (int k = 0; k < int'(DWIDTH); k++) begin
            l[k*HALF +: HALF] = base + 16'(k);
        end
        return l;
    endfunction

    function automatic logic [15:0] hw(input int k);
        return o_packet[k*HALF +: HALF];
    endfunction

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic push_line(input logic [15:0] base, input logic [OFF_W-1:0] off);
        i_fetch_valid  = 1'b1;
        i_fetch_data   = make_line(base);
        i_fetch_offset = off;
        step();
        i_fetch_valid  = 1'b0;
        i_fetch_offset = '0;
    endtask

    task automatic consume(input logic [AVAIL_W-1:0] n);
        i_consume = n;
        step();
        i_consume = '0;
    endtask

    task automatic flush();
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst          = 1'b1;
        i_flush        = 1'b0;
        i_fetch_valid  = 1'b0;
        i_fetch_data   = '0;
        i_fetch_offset = '0;
        i_consume      = '0;
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_count", 32'(o_count), 32'd0);
        check("rst_ready", 32'(o_fetch_ready), 32'd1);
        check("rst_valid", 32'(o_packet_valid), 32'd0);
        check("rst_avail", 32'(o_avail), 32'd0);
        check("rst_packet", 32'(hw(0)), 32'd0);
        i_rst = 1'b0;
        step();

        // Line A, offset 0, visible one cycle after acceptance.
        push_line(16'h1001, 3'd0);
        check("a_count", 32'(o_count), 32'd8);
        check("a_valid", 32'(o_packet_valid), 32'd1);
        check("a_avail", 32'(o_avail), 32'd8);
        check("a_hw0", 32'(hw(0)), 32'h1001);
        check("a_hw7", 32'(hw(7)), 32'h1008);

        // Flush coincident with a valid fetch discards the fetch.
        i_flush       = 1'b1;
        i_fetch_valid = 1'b1;
        i_fetch_data  = make_line(16'h9000);
        step();
        i_flush       = 1'b0;
        i_fetch_valid = 1'b0;
        check("flushfetch_count", 32'(o_count), 32'd0);
        check("flushfetch_valid", 32'(o_packet_valid), 32'd0);

        // Line B entered mid-line at offset 3.
        push_line(16'h2001, 3'd3);
        check("b_count", 32'(o_count), 32'd5);
        check("b_avail", 32'(o_avail), 32'd5);
        check("b_hw0", 32'(hw(0)), 32'h2004);
        check("b_hw4", 32'(hw(4)), 32'h2008);
`ifdef FETCH_BUFFER_PARTIAL_EN
        check("b_valid", 32'(o_packet_valid), 32'd1);
        check("b_hw5_zero", 32'(hw(5)), 32'd0);
`else
        check("b_valid", 32'(o_packet_valid), 32'd0);
`endif

        // Fill to capacity, then a line offered alongside a pop is refused.
        flush();
        push_line(16'h3000, 3'd0);
        push_line(16'h3100, 3'd0);
        push_line(16'h3200, 3'd0);
        check("fill3_ready", 32'(o_fetch_ready), 32'd1);
        push_line(16'h3300, 3'd0);
        check("full_count", 32'(o_count), 32'd32);
        check("full_ready", 32'(o_fetch_ready), 32'd0);
        push_line(16'h3400, 3'd0);
        check("full_refuse", 32'(o_count), 32'd32);
        i_fetch_valid = 1'b1;
        i_fetch_data  = make_line(16'h3500);
        consume(4'd8);
        i_fetch_valid = 1'b0;
        check("drain_count", 32'(o_count), 32'd24);
        check("drain_ready", 32'(o_fetch_ready), 32'd1);
        check("drain_hw0", 32'(hw(0)), 32'h3100);

        // Same-cycle push of 8 and consume of 6 from count 10.
        flush();
        push_line(16'h4000, 3'd0);
        push_line(16'h4100, 3'd6);
        check("ss_pre_count", 32'(o_count), 32'd10);
        i_fetch_valid = 1'b1;
        i_fetch_data  = make_line(16'h4200);
        consume(4'd6);
        i_fetch_valid = 1'b0;
        check("ss_count", 32'(o_count), 32'd12);
        check("ss_hw0", 32'(hw(0)), 32'h4006);
        check("ss_hw2", 32'(hw(2)), 32'h4106);
        check("ss_hw4", 32'(hw(4)), 32'h4200);
        check("ss_hw7", 32'(hw(7)), 32'h4203);

        // Head driven to 29, then a read spanning the ring end.
        flush();
        push_line(16'h5000, 3'd0);
        push_line(16'h5008, 3'd0);
        push_line(16'h5010, 3'd0);
        push_line(16'h5018, 3'd0);
        consume(4'd8);
        consume(4'd8);
        consume(4'd8);
        consume(4'd5);
        check("wrap_pre_count", 32'(o_count), 32'd3);
        push_line(16'h6000, 3'd0);
        check("wrap_count", 32'(o_count), 32'd11);
        check("wrap_hw0", 32'(hw(0)), 32'h501D);
        check("wrap_hw2", 32'(hw(2)), 32'h501F);
        check("wrap_hw3", 32'(hw(3)), 32'h6000);
        check("wrap_hw7", 32'(hw(7)), 32'h6004);

        // Asynchronous reset mid-cycle at count 20.
        flush();
        push_line(16'h7000, 3'd0);
        push_line(16'h7100, 3'd0);
        push_line(16'h7200, 3'd4);
        check("ar_pre_count", 32'(o_count), 32'd20);
        #2;
        i_rst = 1'b1;
        #1;
        check("ar_count", 32'(o_count), 32'd0);
        check("ar_ready", 32'(o_fetch_ready), 32'd1);
        check("ar_valid", 32'(o_packet_valid), 32'd0);
        #2;
        i_rst = 1'b0;
        step();
        check("ar_hold_count", 32'(o_count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
